// File: rtl/alarm_unit.sv
// alarm_unit: stores alarm time, detects alarm/snooze matches and runs the arm/ring/snooze FSM driving ringing and buzz
module alarm_unit #(
  parameter int ALARM_RST_HOUR = 7,
  parameter int ALARM_RST_MIN = 0,
  parameter int SNOOZE_MIN = 5,
  parameter int BUZZ_HALF = 12_500_000,
  parameter longint RING_TIMEOUT = 64'd3_000_000_000
) (
  input logic clk,
  input logic reset,
  input logic [5:0] inSec,
  input logic [5:0] inMin,
  input logic [4:0] inHour,
  input logic armSw,
  input logic setSw,
  input logic keyHourN,
  input logic keyMinN,
  input logic snoozeN,
  input logic stopN,
  output logic [4:0] alarmHour,
  output logic [5:0] alarmMin,
  output logic [1:0] state,
  output logic ringing,
  output logic buzz
);
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, RINGING = 2'd2, SNOOZE = 2'd3;
  localparam int RW = $clog2(RING_TIMEOUT + 1);
  localparam int BW = $clog2(BUZZ_HALF + 1);
  logic [3:0] k1, k2, press;
  logic [1:0] sw;
  logic [1:0] st, nxt;
  logic match, match_q, smatch, smatch_q, trig, strig;
  logic [4:0] snz_hour, snz_h;
  logic [5:0] snz_min;
  logic [6:0] snz_sum;
  logic snz_c;
  logic [RW-1:0] ring_cnt;
  logic [BW-1:0] buzz_cnt;
  logic enter, ring_done, buzz_wrap;
  assign press = k2 & ~k1;
  assign match = inHour == alarmHour && inMin == alarmMin && inSec == 6'd0;
  assign smatch = inHour == snz_hour && inMin == snz_min && inSec == 6'd0;
  assign trig = match & ~match_q;
  assign strig = smatch & ~smatch_q;
  assign snz_sum = {1'b0, inMin} + 7'(SNOOZE_MIN);
  assign snz_c = snz_sum >= 7'd60;
  assign snz_h = inHour + {4'd0, snz_c};
  assign enter = nxt == RINGING && st != RINGING;
  assign ring_done = ring_cnt == RW'(RING_TIMEOUT - 1);
  assign buzz_wrap = buzz_cnt == BW'(BUZZ_HALF - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      k1 <= '1;
      k2 <= '1;
      sw <= '0;
      st <= IDLE;
      match_q <= 1'b0;
      smatch_q <= 1'b0;
      alarmHour <= 5'(ALARM_RST_HOUR);
      alarmMin <= 6'(ALARM_RST_MIN);
      snz_hour <= '0;
      snz_min <= '0;
      ring_cnt <= '0;
      buzz_cnt <= '0;
      buzz <= 1'b0;
    end else begin
      k1 <= {stopN, snoozeN, keyMinN, keyHourN};
      k2 <= k1;
      sw <= {setSw, armSw};
      st <= nxt;
      match_q <= match;
      smatch_q <= smatch;
      if (sw[1] && press[0]) alarmHour <= alarmHour == 5'd23 ? 5'd0 : alarmHour + 5'd1;
      if (sw[1] && press[1]) alarmMin <= alarmMin == 6'd59 ? 6'd0 : alarmMin + 6'd1;
      if (st == RINGING && nxt == SNOOZE) begin
        snz_min <= snz_c ? 6'(snz_sum - 7'd60) : snz_sum[5:0];
        snz_hour <= snz_h == 5'd24 ? 5'd0 : snz_h;
      end
      ring_cnt <= (nxt == RINGING && !enter) ? ring_cnt + RW'(1) : '0;
      buzz_cnt <= (nxt == RINGING && !enter && !buzz_wrap) ? buzz_cnt + BW'(1) : '0;
      buzz <= nxt != RINGING ? 1'b0 : enter ? 1'b1 : buzz_wrap ? ~buzz : buzz;
    end
  end
  always_comb begin
    nxt = st;
    if (sw[1] || !sw[0]) nxt = IDLE;
    else
      case (st)
        IDLE: nxt = ARMED;
        ARMED: nxt = trig ? RINGING : ARMED;
        RINGING: nxt = press[3] ? ARMED : press[2] ? SNOOZE : ring_done ? ARMED : RINGING;
        default: nxt = press[3] ? ARMED : strig ? RINGING : SNOOZE;
      endcase
  end
  always_comb begin
    state = st;
    ringing = st == RINGING;
  end
endmodule

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit: directed and randomized checks of alarm_unit against a minute-arithmetic reference model
module tb_alarm_unit;
  localparam int BH = 4;
  localparam int RT = 100;
  localparam int IDLE = 0, ARMED = 1, RINGING = 2, SNOOZE = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] in_sec = '0, in_min = '0;
  logic [4:0] in_hour = '0;
  logic arm_sw = 1'b0, set_sw = 1'b0;
  logic key_hour_n = 1'b1, key_min_n = 1'b1, snooze_n = 1'b1, stop_n = 1'b1;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [1:0] state;
  logic ringing, buzz;
  int n_vec = 0, n_err = 0;
  int ms, ah, am, sh, smn, age;
  bit mq, smq, set1, arm1;
  bit [3:0] r1, r2;
  always #5 clk = ~clk;
  alarm_unit #(.BUZZ_HALF(BH), .RING_TIMEOUT(RT)) dut (
    .clk(clk), .reset(reset), .inSec(in_sec), .inMin(in_min), .inHour(in_hour),
    .armSw(arm_sw), .setSw(set_sw), .keyHourN(key_hour_n), .keyMinN(key_min_n),
    .snoozeN(snooze_n), .stopN(stop_n), .alarmHour(alarm_hour), .alarmMin(alarm_min),
    .state(state), .ringing(ringing), .buzz(buzz)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_step();
    bit [3:0] p;
    bit mt, smt;
    int nx, tot, ih, im, is;
    if (reset) begin
      ms = IDLE; ah = 7; am = 0; sh = 0; smn = 0; age = 0;
      mq = 0; smq = 0; set1 = 0; arm1 = 0; r1 = '1; r2 = '1;
      return;
    end
    ih = int'(in_hour); im = int'(in_min); is = int'(in_sec);
    p = r2 & ~r1;
    mt = ih == ah && im == am && is == 0;
    smt = ih == sh && im == smn && is == 0;
    nx = ms;
    if (set1 || !arm1) nx = IDLE;
    else if (ms == IDLE) nx = ARMED;
    else if (ms == ARMED) begin
      if (mt && !mq) nx = RINGING;
    end else if (ms == RINGING) begin
      if (p[3]) nx = ARMED;
      else if (p[2]) begin
        nx = SNOOZE;
        tot = (ih * 60 + im + 5) % 1440;
        sh = tot / 60;
        smn = tot % 60;
      end else if (age == RT - 1) nx = ARMED;
    end else begin
      if (p[3]) nx = ARMED;
      else if (smt && !smq) nx = RINGING;
    end
    if (set1 && p[0]) ah = (ah + 1) % 24;
    if (set1 && p[1]) am = (am + 1) % 60;
    age = (nx == RINGING && ms == RINGING) ? age + 1 : 0;
    mq = mt; smq = smt; r2 = r1;
    r1 = {stop_n, snooze_n, key_min_n, key_hour_n};
    set1 = set_sw; arm1 = arm_sw; ms = nx;
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("state", 32'(state), ms);
    chk("ringing", 32'(ringing), 32'(ms == RINGING));
    chk("buzz", 32'(buzz), 32'(ms == RINGING && (age / BH) % 2 == 0));
    chk("alarm_hour", 32'(alarm_hour), ah);
    chk("alarm_min", 32'(alarm_min), am);
  endtask
  task automatic press(input bit h, input bit m, input bit s, input bit p);
    key_hour_n = !h; key_min_n = !m; snooze_n = !s; stop_n = !p;
    tick();
    key_hour_n = 1; key_min_n = 1; snooze_n = 1; stop_n = 1;
    tick();
  endtask
  task automatic set_time(input int h, input int m, input int s);
    in_hour = 5'(h); in_min = 6'(m); in_sec = 6'(s);
  endtask
  task automatic ring_at(input int h, input int m);
    set_time(h, m, 1); tick();
    set_time(h, m, 0); tick();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, r;
    reset = 1; tick();
    chk("rst_state", 32'(state), IDLE);
    chk("rst_hour", 32'(alarm_hour), 7);
    reset = 0;
    set_sw = 1;
    repeat (3) tick();
    for (int i = 0; i < 61; i++) press(i < 18, 1, 0, 0);
    chk("edit_hour", 32'(alarm_hour), 1);
    chk("edit_min", 32'(alarm_min), 1);
    chk("edit_state", 32'(state), IDLE);
    set_sw = 0;
    reset = 1; tick(); reset = 0;
    arm_sw = 1;
    set_time(6, 59, 59);
    repeat (3) tick();
    chk("armed", 32'(state), ARMED);
    set_time(7, 0, 0); tick();
    chk("trig_ring", 32'(ringing), 1);
    chk("buzz_seq", 32'(buzz), 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("buzz_seq", 32'(buzz), 32'(i < 4));
    end
    press(0, 0, 0, 1);
    chk("stop", 32'(state), ARMED);
    repeat (1000) tick();
    chk("no_retrig", 32'(state), ARMED);
    ring_at(7, 0);
    chk("retrig", 32'(ringing), 1);
    n = 1;
    while (ringing && n < 200) begin
      tick();
      if (ringing) n++;
    end
    chk("ring_len", n, RT);
    chk("timeout_buzz", 32'(buzz), 0);
    chk("timeout_state", 32'(state), ARMED);
    set_sw = 1;
    repeat (3) tick();
    for (int i = 0; i < 57; i++) press(i < 16, 1, 0, 0);
    set_sw = 0;
    repeat (3) tick();
    chk("set2_hour", 32'(alarm_hour), 23);
    chk("set2_min", 32'(alarm_min), 57);
    chk("rearm", 32'(state), ARMED);
    set_time(23, 56, 59); tick();
    set_time(23, 57, 0); tick();
    chk("ring_2357", 32'(ringing), 1);
    press(0, 0, 1, 0);
    chk("snooze", 32'(state), SNOOZE);
    set_time(0, 1, 59);
    repeat (3) tick();
    chk("snz_early", 32'(state), SNOOZE);
    set_time(0, 2, 0); tick();
    chk("snz_wrap", 32'(ringing), 1);
    press(0, 0, 1, 1);
    chk("stop_over_snz", 32'(state), ARMED);
    set_time(23, 56, 59); tick();
    set_time(23, 57, 0); tick();
    chk("ring_b", 32'(ringing), 1);
    set_sw = 1;
    repeat (2) tick();
    chk("set_idle", 32'(state), IDLE);
    set_sw = 0;
    repeat (3) tick();
    set_time(23, 56, 59); tick();
    set_time(23, 57, 0); tick();
    chk("ring_c", 32'(ringing), 1);
    press(0, 0, 1, 0);
    chk("snooze_c", 32'(state), SNOOZE);
    arm_sw = 0;
    repeat (2) tick();
    chk("disarm_idle", 32'(state), IDLE);
    arm_sw = 1;
    repeat (3) tick();
    ring_at(23, 57);
    repeat (3) tick();
    chk("ring_d", 32'(ringing), 1);
    reset = 1; tick(); reset = 0;
    chk("mid_rst_state", 32'(state), IDLE);
    chk("mid_rst_ring", 32'(ringing), 0);
    chk("mid_rst_buzz", 32'(buzz), 0);
    chk("mid_rst_hour", 32'(alarm_hour), 7);
    chk("mid_rst_min", 32'(alarm_min), 0);
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, 29) == 0) set_sw = !set_sw;
      if ($urandom_range(0, 59) == 0) arm_sw = !arm_sw;
      if (set_sw && $urandom_range(0, 3) == 0) set_sw = 0;
      if (!arm_sw && $urandom_range(0, 3) == 0) arm_sw = 1;
      key_hour_n = $urandom_range(0, 15) != 0;
      key_min_n = $urandom_range(0, 15) != 0;
      snooze_n = $urandom_range(0, 47) != 0;
      stop_n = $urandom_range(0, 63) != 0;
      r = int'($urandom_range(0, 9));
      if (r < 4) set_time(ah, am, 0);
      else if (r < 7) set_time(sh, smn, 0);
      else set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), 0);
      if ($urandom_range(0, 1) == 0) in_sec = 6'($urandom_range(1, 59));
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
